// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants and the fetch-entry layout used by fetch and decode
package rv32_pkg;
    localparam int XLEN = 32;
    localparam int FETCH_ENTRY_W = 2 * XLEN;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: first-word fall-through FIFO with synchronous flush
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + AW'(pop);
            wptr  <= wptr + AW'(push);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push && !flush) mem[wptr] <= din;
    assign dout  = mem[rptr];
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from combinational imem and buffers {pc, instr} for decode
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_address,
    input  logic [XLEN-1:0] imem_instruction,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            misaligned,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instruction
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [XLEN-1:0] pc;
    logic push, pop, full, empty;
    logic [CW-1:0] count;
    logic [FETCH_ENTRY_W-1:0] dout;
    fetch_entry_t head;
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(FETCH_ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({pc, imem_instruction}),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign head = fetch_entry_t'(dout);
    assign out_valid = !empty;
    assign pop = out_valid && out_ready;
    // A full FIFO can still accept when the head leaves in the same cycle
    assign push = !redirect_valid && (!full || pop);
    assign imem_address = {2'b00, pc[XLEN-1:2]};
    assign out_pc = out_valid ? head.pc : '0;
    assign out_instruction = out_valid ? head.instr : NOP_INSTR;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            misaligned <= 1'b0;
        end else begin
            pc         <= redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : push ? pc + PC_STEP : pc;
            misaligned <= redirect_valid && |redirect_pc[1:0];
        end
    end
    count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(FIFO_DEPTH));
endmodule
